// File: rtl/display_7seg_scan.sv
// Multiplexed N-digit seven-segment scanner: hex decode, decimal points, blank/blink,
// PWM brightness, one dead cycle per slot, frame tick. All pin outputs registered, active-low.
module display_7seg_scan #(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_CYCLES = 100000,
   parameter int BRIGHT_W       = 4,
   parameter int BLINK_DIV      = 50000000
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [4*N_DIGITS-1:0]   digits,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     blank,
   input  logic [N_DIGITS-1:0]     blink_en,
   input  logic [BRIGHT_W-1:0]     bright,
   output logic [0:6]              seg,
   output logic                    dp,
   output logic [0:N_DIGITS-1]     an,
   output logic                    frame_tick
);

   localparam int SEL_W = $clog2(N_DIGITS);
   localparam int CNT_W = $clog2(REFRESH_CYCLES);
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;  default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [BRIGHT_W-1:0] pwm_q, pwm_d;
   logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                blink_ph_q, blink_ph_d;
   logic [0:6]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [0:N_DIGITS-1] an_q, an_d;
   logic                frame_tick_q, frame_tick_d;

   logic                cnt_wrap;
   logic                lit_pwm;
   logic [N_DIGITS-1:0] vis;
   logic [6:0]          dec_seg [N_DIGITS];

   assign cnt_wrap = (cnt_q == CNT_MAX);
   assign lit_pwm  = (&bright) | (pwm_q < bright);

   // One-hot visibility per digit; a sel value beyond the last digit matches nothing and stays dark.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign dec_seg[gi] = hex_decode(digits[4*gi +: 4]);
         assign vis[gi]     = (sel_q == SEL_W'(gi)) && !blank[gi]
                              && !(blink_en[gi] && blink_ph_q)
                              && lit_pwm && (cnt_q != '0);
         assign an_d[gi]    = ~vis[gi];
      end
   endgenerate

   always_comb begin
      cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
      sel_d        = sel_q;
      if (cnt_wrap) begin
         sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      end
      pwm_d        = pwm_q + 1'b1;
      blink_cnt_d  = (blink_cnt_q == BLK_MAX) ? '0 : blink_cnt_q + 1'b1;
      blink_ph_d   = (blink_cnt_q == BLK_MAX) ? ~blink_ph_q : blink_ph_q;
      frame_tick_d = cnt_wrap && (sel_q == SEL_MAX);
      seg_d        = '1;
      dp_d         = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (vis[i]) begin
            seg_d = dec_seg[i];
            dp_d  = ~dp_in[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q        <= '0;
         sel_q        <= '0;
         pwm_q        <= '0;
         blink_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         seg_q        <= '1;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         pwm_q        <= pwm_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_ph_q   <= blink_ph_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_7seg_scan.sv
// Bench for display_7seg_scan: time-indexed scan model compared every cycle,
// directed scenarios with literal expectations, then randomized inputs and resets.
module tb_display_7seg_scan;

   localparam int N  = 4;
   localparam int R  = 8;
   localparam int BW = 2;
   localparam int BD = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [15:0]   digits = 16'h3210;
   logic [3:0]    dp_in = 4'b0000;
   logic [3:0]    blank = 4'b0000;
   logic [3:0]    blink_en = 4'b0000;
   logic [BW-1:0] bright = 2'd3;
   logic [0:6]    seg;
   logic          dp;
   logic [0:3]    an;
   logic          frame_tick;

   display_7seg_scan #(
      .N_DIGITS(N), .REFRESH_CYCLES(R), .BRIGHT_W(BW), .BLINK_DIV(BD)
   ) dut (
      .CLK(CLK), .RST(RST), .digits(digits), .dp_in(dp_in), .blank(blank),
      .blink_en(blink_en), .bright(bright), .seg(seg), .dp(dp), .an(an),
      .frame_tick(frame_tick)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0b expected=%0b at %0t", name, got, exp, $time);
      end
   endtask

   // Segment patterns a..g, active-low, for hex 0..F.
   logic [6:0] dec_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Model: mt counts cycles since reset; every scan quantity is plain arithmetic on mt.
   int         mt = 0;
   bit         valid = 1'b0;
   int         m_cnt, m_sel, m_pwm, m_ph;
   bit         m_vis;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic       exp_ft;

   always @(posedge CLK) begin
      if (RST) begin
         mt      <= 0;
         valid   <= 1'b1;
         exp_an  <= 4'hF;
         exp_seg <= 7'h7F;
         exp_dp  <= 1'b1;
         exp_ft  <= 1'b0;
      end else if (valid) begin
         m_cnt = mt % R;
         m_sel = (mt / R) % N;
         m_pwm = mt % (1 << BW);
         m_ph  = (mt / BD) % 2;
         m_vis = !blank[m_sel] && !(blink_en[m_sel] && m_ph == 1)
                 && (bright == 2'd3 || m_pwm < int'(bright)) && m_cnt != 0;
         exp_an  <= m_vis ? ~(4'b1000 >> m_sel) : 4'hF;
         exp_seg <= m_vis ? dec_tab[digits[4*m_sel +: 4]] : 7'h7F;
         exp_dp  <= m_vis ? ~dp_in[m_sel] : 1'b1;
         exp_ft  <= (mt % (R*N)) == (R*N - 1);
         mt      <= mt + 1;
      end
   end

   always @(negedge CLK) begin
      if (valid) begin
         check("model_an", an, exp_an);
         check("model_seg", seg, exp_seg);
         check("model_dp", dp, exp_dp);
         check("model_frame_tick", frame_tick, exp_ft);
      end
   end

   task automatic wait_phase(input int ph);
      int k;
      k = 0;
      while ((mt % (R*N)) != ph && k < 100) begin
         @(negedge CLK);
         k++;
      end
      if ((mt % (R*N)) != ph) begin
         checks++;
         errors++;
         $display("FAIL wait_phase timeout got=%0d expected=%0d", mt % (R*N), ph);
      end
   endtask

   task automatic count_an(input logic [3:0] pat, input bit any, input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge CLK);
         if (any ? (an != 4'hF) : (an == pat)) n++;
      end
   endtask

   int n;

   initial begin
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("reset_an", an, 4'hF);
      check("reset_seg", seg, 7'h7F);
      check("reset_dp", dp, 1'b1);
      check("reset_ft", frame_tick, 1'b0);
      RST = 1'b0;

      // Scan sequence
      @(negedge CLK); check("scan_dead0", an, 4'hF);
      @(negedge CLK); check("scan_an0", an, 4'b0111); check("scan_seg0", seg, 7'b0000001);
      repeat (8) @(negedge CLK);
      check("scan_an1", an, 4'b1011); check("scan_seg1", seg, 7'b1001111);
      repeat (8) @(negedge CLK);
      check("scan_an2", an, 4'b1101); check("scan_seg2", seg, 7'b0010010);
      repeat (8) @(negedge CLK);
      check("scan_an3", an, 4'b1110); check("scan_seg3", seg, 7'b0000110);
      repeat (6) @(negedge CLK); check("scan_ft_on", frame_tick, 1'b1);
      @(negedge CLK);            check("scan_ft_off", frame_tick, 1'b0);

      // Hex decode and decimal point on digit 0
      wait_phase(3);
      digits[3:0] = 4'hA;
      dp_in = 4'b0001;
      @(negedge CLK);
      check("hex_A_seg", seg, 7'b0001000);
      check("hex_A_dp", dp, 1'b0);
      check("hex_A_an", an, 4'b0111);
      for (int i = 0; i < 64; i++) begin
         digits[3:0] = 4'(i);
         @(negedge CLK);
      end
      dp_in = 4'b0000;

      // Brightness
      bright = 2'd1;
      count_an(4'h0, 1'b1, 32, n); check("bright1_count", n, 4);
      bright = 2'd0;
      count_an(4'h0, 1'b1, 32, n); check("bright0_count", n, 0);
      bright = 2'd3;

      // Blank and blink
      blank = 4'b0100;
      count_an(4'b1101, 1'b0, 32, n); check("blank_dig2", n, 0);
      count_an(4'h0, 1'b1, 32, n);    check("blank_others", n, 21);
      blank = 4'b0000;
      blink_en = 4'b0001;
      count_an(4'b0111, 1'b0, 64, n); check("blink_dig0", n, 7);
      blink_en = 4'b0000;

      // Reset while sel=2, cnt=5
      wait_phase(21);
      RST = 1'b1;
      @(negedge CLK);
      check("midrst_an", an, 4'hF);
      check("midrst_seg", seg, 7'h7F);
      check("midrst_dp", dp, 1'b1);
      check("midrst_ft", frame_tick, 1'b0);
      RST = 1'b0;
      @(negedge CLK); check("midrst_dead", an, 4'hF);
      @(negedge CLK); check("midrst_first", an, 4'b0111);

      // Randomized inputs with occasional resets
      for (int s = 0; s < 80; s++) begin
         digits   = 16'($urandom);
         dp_in    = 4'($urandom);
         blank    = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
         blink_en = 4'($urandom);
         bright   = 2'($urandom);
         RST      = ($urandom_range(0, 9) == 0);
         @(negedge CLK);
         RST = 1'b0;
         repeat ($urandom_range(1, 40)) @(negedge CLK);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
